// File: rtl/imm_extend_pipe.sv
// Pipelined LEGv8 immediate generator.
// The instruction word is decoded combinationally, captured into stage 0 and
// then carried through STAGES-1 further register stages under valid/ready
// flow control. Outputs come straight from the last stage's registers.
module imm_extend_pipe #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STAGES       = 1,
    parameter int unsigned BRANCH_SCALE = 1,
    parameter int unsigned TAG_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic [2:0]        fmt,
    output logic              illegal,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [2:0] {
        FmtNone  = 3'd0,
        FmtB     = 3'd1,
        FmtCb    = 3'd2,
        FmtBcond = 3'd3,
        FmtD     = 3'd4,
        FmtShamt = 3'd5,
        FmtAlui  = 3'd6,
        FmtWide  = 3'd7
    } fmt_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    // All formats are built in a 64-bit working value and truncated to
    // DATA_W; truncating a 64-bit sign extension is a correct narrower one.
    logic [63:0]       dec_full;
    logic [63:0]       wide_val;
    logic [1:0]        hw;
    fmt_e              dec_fmt;
    logic              dec_ill;
    logic [DATA_W-1:0] dec_imm;

    assign hw       = instr[22:21];
    assign wide_val = {48'b0, instr[20:5]} << {hw, 4'b0000};

    // Opcode match in priority order; unmatched words give NONE with imm 0
    always_comb begin
        dec_full = '0;
        dec_fmt  = FmtNone;
        dec_ill  = 1'b0;
        if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
            dec_fmt  = FmtB;
            dec_full = {{38{instr[25]}}, instr[25:0]};
        end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101) begin
            dec_fmt  = FmtCb;
            dec_full = {{45{instr[23]}}, instr[23:5]};
        end else if (instr[31:24] == 8'b01010100) begin
            dec_fmt  = FmtBcond;
            dec_full = {{45{instr[23]}}, instr[23:5]};
        end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
            dec_fmt  = FmtD;
            dec_full = {{55{instr[20]}}, instr[20:12]};
        end else if (instr[31:21] == 11'b11010011011 || instr[31:21] == 11'b11010011010) begin
            dec_fmt  = FmtShamt;
            dec_full = {58'b0, instr[15:10]};
        end else if (instr[31:22] inside {10'b1001000100, 10'b1101000100, 10'b1011000100,
                                          10'b1111000100, 10'b1001001000, 10'b1011001000,
                                          10'b1101001000, 10'b1111001000}) begin
            dec_fmt  = FmtAlui;
            dec_full = {52'b0, instr[21:10]};
        end else if (instr[31:23] == 9'b110100101 || instr[31:23] == 9'b111100101) begin
            dec_fmt = FmtWide;
            // A 32-bit datapath cannot hold a half-word placed at bit 32 or 48
            if (DATA_W == 32 && hw[1]) begin
                dec_ill = 1'b1;
            end else begin
                dec_full = wide_val;
            end
        end
        // Byte-offset scaling for branches; overflowing top bits are dropped
        if (BRANCH_SCALE != 0 && dec_fmt inside {FmtB, FmtCb, FmtBcond}) begin
            dec_full = dec_full << 2;
        end
    end

    assign dec_imm = dec_full[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ill_q, ill_d;
    logic [DATA_W-1:0] imm_q [STAGES];
    logic [DATA_W-1:0] imm_d [STAGES];
    fmt_e              fmt_q [STAGES];
    fmt_e              fmt_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_ill;
    logic [DATA_W-1:0] up_imm [STAGES];
    fmt_e              up_fmt [STAGES];
    logic [TAG_W-1:0]  up_tag [STAGES];

    logic [STAGES:0]   ready;

    // Ready chain from the consumer back to stage 0; an empty stage is
    // always ready so bubbles collapse even while the output is stalled
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_q[k] || ready[k+1];
        end
    end

    assign in_ready = ready[0];

    // Upstream source of each stage: decode for stage 0, previous stage otherwise
    always_comb begin
        up_valid[0] = in_valid;
        up_ill[0]   = dec_ill;
        up_imm[0]   = dec_imm;
        up_fmt[0]   = dec_fmt;
        up_tag[0]   = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = valid_q[k-1];
            up_ill[k]   = ill_q[k-1];
            up_imm[k]   = imm_q[k-1];
            up_fmt[k]   = fmt_q[k-1];
            up_tag[k]   = tag_q[k-1];
        end
    end

    // Next state: load from upstream when ready, otherwise hold; flush
    // only drops valid bits, so an output handshake this cycle still counts
    always_comb begin
        valid_d = valid_q;
        ill_d   = ill_q;
        for (int k = 0; k < STAGES; k++) begin
            imm_d[k] = imm_q[k];
            fmt_d[k] = fmt_q[k];
            tag_d[k] = tag_q[k];
            if (ready[k]) begin
                valid_d[k] = up_valid[k];
                ill_d[k]   = up_ill[k];
                imm_d[k]   = up_imm[k];
                fmt_d[k]   = up_fmt[k];
                tag_d[k]   = up_tag[k];
            end
            if (flush) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Stage registers; synchronous reset clears valids and zeros payloads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ill_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                fmt_q[k] <= FmtNone;
                tag_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ill_q   <= ill_d;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= imm_d[k];
                fmt_q[k] <= fmt_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign imm       = imm_q[STAGES-1];
    assign fmt       = fmt_q[STAGES-1];
    assign illegal   = ill_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed decode cases on two single-stage
// instances (64-bit scaled, 32-bit unscaled) and flow-control cases on a
// three-stage instance, all checked through expected-result queues.
module tb_imm_extend_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Group A drives u_a (64-bit, scaled) and u_b (32-bit, unscaled)
    logic        a_rst_n, a_flush, a_in_valid, a_out_ready;
    logic [31:0] a_instr;
    logic [7:0]  a_in_tag;
    logic        ua_in_ready, ua_out_valid, ua_illegal;
    logic [63:0] ua_imm;
    logic [2:0]  ua_fmt;
    logic [7:0]  ua_out_tag;
    logic        ub_in_ready, ub_out_valid, ub_illegal;
    logic [31:0] ub_imm;
    logic [2:0]  ub_fmt;
    logic [7:0]  ub_out_tag;

    // Group S drives u_s (three stages)
    logic        s_rst_n, s_flush, s_in_valid, s_out_ready;
    logic [31:0] s_instr;
    logic [7:0]  s_in_tag;
    logic        s_in_ready, s_out_valid, s_illegal;
    logic [63:0] s_imm;
    logic [2:0]  s_fmt;
    logic [7:0]  s_out_tag;

    imm_extend_pipe u_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(ua_in_ready), .instr(a_instr), .in_tag(a_in_tag),
        .out_valid(ua_out_valid), .out_ready(a_out_ready), .imm(ua_imm), .fmt(ua_fmt),
        .illegal(ua_illegal), .out_tag(ua_out_tag)
    );

    imm_extend_pipe #(.DATA_W(32), .BRANCH_SCALE(0)) u_b (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(ub_in_ready), .instr(a_instr), .in_tag(a_in_tag),
        .out_valid(ub_out_valid), .out_ready(a_out_ready), .imm(ub_imm), .fmt(ub_fmt),
        .illegal(ub_illegal), .out_tag(ub_out_tag)
    );

    imm_extend_pipe #(.STAGES(3)) u_s (
        .clk(clk), .rst_n(s_rst_n), .flush(s_flush), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .instr(s_instr), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .imm(s_imm), .fmt(s_fmt),
        .illegal(s_illegal), .out_tag(s_out_tag)
    );

    exp_t q_a[$], q_b[$], q_s[$];
    exp_t nxt_a, nxt_b, nxt_s;
    int   passed = 0, total = 0, fails = 0;
    int   s_outs = 0;
    logic a_acc, s_acc;
    logic s_stall_prev = 1'b0;
    logic [63:0] s_imm_prev;
    logic [7:0]  s_tag_prev;

    logic [31:0] st_instr [6] = '{32'hF8500041, 32'h17FFFFFF, 32'hB4000200,
                                  32'hD2F579A0, 32'hD360FC00, 32'h913FFC00};
    logic [63:0] st_imm   [6] = '{64'hFFFFFFFFFFFFFF00, 64'hFFFFFFFFFFFFFFFC, 64'h40,
                                  64'hABCD000000000000, 64'h3F, 64'hFFF};
    logic [2:0]  st_fmt   [6] = '{3'd4, 3'd1, 3'd2, 3'd7, 3'd5, 3'd6};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic pop_cmp(input string pfx, input logic [63:0] imm_o, input logic [2:0] fmt_o,
                           input logic ill_o, input logic [7:0] tag_o, input exp_t e);
        chk({pfx, "_imm"}, imm_o, e.imm);
        chk({pfx, "_fmt"}, 64'(fmt_o), 64'(e.fmt));
        chk({pfx, "_illegal"}, 64'(ill_o), 64'(e.ill));
        chk({pfx, "_tag"}, 64'(tag_o), 64'(e.tag));
    endtask

    // One clock cycle: inputs already driven; check, update queues, advance
    task automatic tick();
        exp_t e;
        logic exp_rdy;
        #1;
        a_acc = 1'b0;
        s_acc = 1'b0;
        if (a_rst_n) begin
            exp_rdy = !(q_a.size() == 1 && !a_out_ready);
            chk("a_in_ready", 64'(ua_in_ready), 64'(exp_rdy));
            if (ua_out_valid && a_out_ready) begin
                if (q_a.size() == 0) chk("a_unexpected_out", 64'(ua_out_valid), 64'(0));
                else begin
                    e = q_a.pop_front();
                    pop_cmp("a", ua_imm, ua_fmt, ua_illegal, ua_out_tag, e);
                end
            end
            if (ub_out_valid && a_out_ready) begin
                if (q_b.size() == 0) chk("b_unexpected_out", 64'(ub_out_valid), 64'(0));
                else begin
                    e = q_b.pop_front();
                    pop_cmp("b", 64'(ub_imm), ub_fmt, ub_illegal, ub_out_tag, e);
                end
            end
        end
        if (!a_rst_n || a_flush) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_in_valid && ua_in_ready) begin
                q_a.push_back(nxt_a);
                a_acc = 1'b1;
            end
            if (a_in_valid && ub_in_ready) q_b.push_back(nxt_b);
        end

        if (s_rst_n) begin
            exp_rdy = !(q_s.size() == 3 && !s_out_ready);
            chk("s_in_ready", 64'(s_in_ready), 64'(exp_rdy));
            if (s_stall_prev) begin
                chk("s_stall_valid", 64'(s_out_valid), 64'(1));
                chk("s_stall_imm", s_imm, s_imm_prev);
                chk("s_stall_tag", 64'(s_out_tag), 64'(s_tag_prev));
            end
            if (s_out_valid && s_out_ready) begin
                s_outs++;
                if (q_s.size() == 0) chk("s_unexpected_out", 64'(s_out_valid), 64'(0));
                else begin
                    e = q_s.pop_front();
                    pop_cmp("s", s_imm, s_fmt, s_illegal, s_out_tag, e);
                end
            end
        end
        s_stall_prev = s_rst_n && !s_flush && s_out_valid && !s_out_ready;
        s_imm_prev   = s_imm;
        s_tag_prev   = s_out_tag;
        if (!s_rst_n || s_flush) begin
            q_s.delete();
        end else if (s_in_valid && s_in_ready) begin
            q_s.push_back(nxt_s);
            s_acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] w, input logic [7:0] tg,
                          input logic [63:0] ia, input logic [2:0] fa, input logic la,
                          input logic [63:0] ib, input logic [2:0] fb, input logic lb);
        a_in_valid = 1'b1;
        a_instr    = w;
        a_in_tag   = tg;
        nxt_a      = '{imm: ia, fmt: fa, ill: la, tag: tg};
        nxt_b      = '{imm: ib, fmt: fb, ill: lb, tag: tg};
        tick();
        chk("a_accept", 64'(a_acc), 64'(1));
    endtask

    task automatic set_s(input int idx, input logic [7:0] tg);
        s_in_valid = 1'b1;
        s_instr    = st_instr[idx];
        s_in_tag   = tg;
        nxt_s      = '{imm: st_imm[idx], fmt: st_fmt[idx], ill: 1'b0, tag: tg};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int sent;
        a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_instr = '0; a_in_tag = '0;
        s_rst_n = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        s_instr = '0; s_in_tag = '0;
        nxt_a = '0; nxt_b = '0; nxt_s = '0;
        tick();
        tick();
        a_rst_n = 1'b1;
        s_rst_n = 1'b1;

        // Reset state
        chk("rst_a_out_valid", 64'(ua_out_valid), 64'(0));
        chk("rst_a_imm", ua_imm, 64'(0));
        chk("rst_a_fmt", 64'(ua_fmt), 64'(0));
        chk("rst_a_illegal", 64'(ua_illegal), 64'(0));
        chk("rst_a_out_tag", 64'(ua_out_tag), 64'(0));
        chk("rst_a_in_ready", 64'(ua_in_ready), 64'(1));
        chk("rst_b_imm", 64'(ub_imm), 64'(0));
        chk("rst_s_out_valid", 64'(s_out_valid), 64'(0));
        chk("rst_s_in_ready", 64'(s_in_ready), 64'(1));

        // Directed decodes: 64-bit scaled (a) and 32-bit unscaled (b)
        send_a(32'hF8500041, 8'h01, 64'hFFFFFFFFFFFFFF00, 3'd4, 1'b0, 64'hFFFFFF00, 3'd4, 1'b0);
        chk("a_latency_valid", 64'(ua_out_valid), 64'(1));
        send_a(32'h17FFFFFF, 8'h02, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFF, 3'd1, 1'b0);
        send_a(32'hB4000200, 8'h03, 64'h40, 3'd2, 1'b0, 64'h10, 3'd2, 1'b0);
        send_a(32'hD2F579A0, 8'h04, 64'hABCD000000000000, 3'd7, 1'b0, 64'h0, 3'd7, 1'b1);
        send_a(32'hD360FC00, 8'h05, 64'h3F, 3'd5, 1'b0, 64'h3F, 3'd5, 1'b0);
        send_a(32'h913FFC00, 8'h06, 64'hFFF, 3'd6, 1'b0, 64'hFFF, 3'd6, 1'b0);
        send_a(32'h00000000, 8'h07, 64'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
        send_a(32'h54FFFFE0, 8'h08, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF, 3'd3, 1'b0);
        send_a(32'hF2A24680, 8'h09, 64'h12340000, 3'd7, 1'b0, 64'h12340000, 3'd7, 1'b0);
        send_a(32'hF80FF000, 8'h0A, 64'hFF, 3'd4, 1'b0, 64'hFF, 3'd4, 1'b0);
        send_a(32'h8B020020, 8'h0B, 64'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
        send_a(32'hD2C00020, 8'h0C, 64'h100000000, 3'd7, 1'b0, 64'h0, 3'd7, 1'b1);
        a_in_valid = 1'b0;
        tick();
        tick();
        chk("a_drained", 64'(q_a.size()), 64'(0));
        chk("b_drained", 64'(q_b.size()), 64'(0));

        // Three-stage stream with a four-cycle output stall mid-stream
        sent   = 0;
        s_outs = 0;
        for (int c = 0; c < 60 && (sent < 6 || q_s.size() != 0); c++) begin
            s_out_ready = !(c >= 3 && c < 7);
            if (sent < 6) set_s(sent, 8'(8'h10 + sent));
            else s_in_valid = 1'b0;
            tick();
            if (s_acc) sent++;
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        chk("s_stream_sent", 64'(sent), 64'(6));
        chk("s_stream_outs", 64'(s_outs), 64'(6));
        chk("s_stream_drained", 64'(q_s.size()), 64'(0));

        // Flush with two entries in flight and a new input offered
        s_outs = 0;
        set_s(0, 8'h20);
        tick();
        set_s(1, 8'h21);
        tick();
        s_flush = 1'b1;
        set_s(2, 8'h22);
        tick();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        chk("s_flush_out_valid", 64'(s_out_valid), 64'(0));
        for (int i = 0; i < 5; i++) tick();
        chk("s_flush_no_outs", 64'(s_outs), 64'(0));

        // One-edge reset mid-stream
        set_s(0, 8'h30);
        tick();
        set_s(3, 8'h31);
        tick();
        set_s(4, 8'h32);
        tick();
        s_rst_n = 1'b0;
        set_s(5, 8'h33);
        tick();
        s_rst_n    = 1'b1;
        s_in_valid = 1'b0;
        chk("s_rst_out_valid", 64'(s_out_valid), 64'(0));
        chk("s_rst_imm", s_imm, 64'(0));
        chk("s_rst_fmt", 64'(s_fmt), 64'(0));
        chk("s_rst_illegal", 64'(s_illegal), 64'(0));
        chk("s_rst_out_tag", 64'(s_out_tag), 64'(0));
        chk("s_rst_in_ready", 64'(s_in_ready), 64'(1));
        s_outs = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("s_rst_no_outs", 64'(s_outs), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
